div_req_sequencer: RTL and testbench
====================================

# div_req_sequencer

Front-end sequencer placed directly upstream of the iterative restoring divider. It accepts divide requests over a valid/ready handshake and buffers them in a small FIFO. It issues each request to the divider using the divider's start-pulse protocol, holding the operands stable for the whole operation. It captures quotient and remainder on completion and returns them over a valid/ready response port, resolving divide-by-zero and signed overflow locally without invoking the divider.

## Interface
- DIV_WIDTH, 32, operand/result width; must match the divider.
- FIFO_DEPTH, 4, request FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with DIV_SEQ_TIMEOUT_EN.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid / req_ready  in / out  1  request handshake.
- req_sign, req_dividend, req_divisor  in  1, DIV_WIDTH, DIV_WIDTH  request payload; sign=1 selects two's-complement.
- div_start  out  1  start pulse to divider.
- div_sign, div_in1, div_in2  out  1, DIV_WIDTH, DIV_WIDTH  operands to divider.
- div_q, div_r, div_ready  in  DIV_WIDTH, DIV_WIDTH, 1  divider results and ready.
- rsp_valid / rsp_ready  out / in  1  response handshake.
- rsp_q, rsp_r  out  DIV_WIDTH  registered quotient and remainder.
- rsp_dbz, rsp_ovf, rsp_tmo  out  1  flags: divide-by-zero, signed overflow, timeout (rsp_tmo is tied to 0 when the watchdog is compiled out).

## Operation
- Requests enter the FIFO on req_valid && req_ready. req_ready = !fifo_full, forced to 0 while rst_n=0.
- FSM states and transitions:
  - IDLE: when the FIFO is non-empty, pop the head into the operand register. Go to BYPASS if the request is a special case, otherwise to START.
  - START: drive div_start=1 for exactly one cycle, then go to WAIT.
  - WAIT: drive div_start=0. When div_ready=1, capture div_q/div_r into rsp_q/rsp_r and go to RESP.
  - BYPASS: load the special-case result and go to RESP.
  - RESP: hold rsp_valid=1. When rsp_ready=1, go to IDLE.
- div_in1, div_in2 and div_sign are driven from the operand register. They must stay constant from START until the RESP entry edge, because the divider reads them combinationally while running.
- Special cases, decoded in IDLE from the popped entry:
  - Divisor is 0: rsp_q = all ones, rsp_r = dividend, rsp_dbz=1.
  - sign=1, dividend = 1<<(DIV_WIDTH-1) and divisor = all ones: rsp_q = dividend, rsp_r = 0, rsp_ovf=1.
  - In both cases the divider is never started; it would otherwise not terminate.
- A single operation is in flight at a time; no overlap with the divider.

## Timing
- Reset values: rsp_valid=0, rsp_q=0, rsp_r=0, all flags 0, div_start=0, operand register 0, FIFO empty, FSM in IDLE.
- Divider handshake, with cycle 0 = START:
  - Cycle 0: div_start=1.
  - Cycle 1: div_start=0; the divider drops div_ready.
  - The first div_ready=1 seen in WAIT marks completion.
  - Divider latency is data dependent (≈ |quotient|+3 cycles).
- Fixed sequencer overhead:
  - Normal path: request-to-rsp_valid is ≥ 2 cycles plus divider latency (IDLE pop, START, then WAIT). rsp_valid rises the cycle after div_ready is sampled high.
  - Bypass path: rsp_valid rises 2 cycles after the pop.
- Response registers change only on the RESP entry edge and are stable while rsp_valid=1.
- A FIFO push and pop in the same cycle are both honoured, including when the FIFO is full.
- Reset mid-operation aborts everything. Because the divider shares rst_n, both blocks return to idle together; no response is produced for the aborted request.

## Configuration
- DIV_SEQ_TIMEOUT_EN defined: a WAIT-state cycle counter is compiled in.
  - When the counter reaches TIMEOUT_CYCLES, go to RESP with rsp_q=0, rsp_r=0, rsp_tmo=1.
  - The sequencer does not attempt to recover the divider; the system must assert rst_n.
- DIV_SEQ_TIMEOUT_EN undefined: no counter; WAIT is left only on div_ready.

## Structure
- Package div_pkg holds:
  - the FSM state enum (IDLE, START, WAIT, BYPASS, RESP);
  - the request struct {sign, dividend, divisor};
  - the constants for the all-ones and signed-minimum patterns.
- Sub-module div_req_fifo: synchronous FIFO, parameterised by width and depth, exposing full/empty. It is instantiated once; FSM and result capture live in the top module.

## Test plan
- Unsigned 100/7 -> rsp_q=14, rsp_r=2, all flags 0. div_start is high for exactly one cycle.
- Signed -100/7 -> rsp_q=0xFFFFFFF2, rsp_r=0xFFFFFFFE.
- 5/0 unsigned -> rsp_q=0xFFFFFFFF, rsp_r=5, rsp_dbz=1, div_start never asserted. Signed 0x80000000/0xFFFFFFFF -> rsp_q=0x80000000, rsp_r=0, rsp_ovf=1.
- With rsp_ready=0, push 6 requests -> 4 accepted into the FIFO, one held in RESP, req_ready=0. Releasing rsp_ready drains all of them in order with correct results. Operands must stay stable throughout WAIT.
- Assert rst_n=0 during WAIT -> the next cycle shows all outputs at reset values and the FIFO empty. A new request afterwards completes normally.
- With DIV_SEQ_TIMEOUT_EN, use a divider model that holds div_ready low -> rsp_tmo=1 exactly TIMEOUT_CYCLES cycles after WAIT entry.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the divide-request sequencer and its request FIFO.
package div_pkg;

    localparam int DIV_W = 32;

    localparam logic [DIV_W-1:0] ALL_ONES   = '1;
    localparam logic [DIV_W-1:0] SIGNED_MIN = {1'b1, {(DIV_W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_BYPASS = 3'd3,
        ST_RESP   = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic             sign;
        logic [DIV_W-1:0] dividend;
        logic [DIV_W-1:0] divisor;
    } div_req_t;

    function automatic logic is_dbz(input div_req_t r);
        return (r.divisor == '0);
    endfunction

    // Signed minimum divided by -1 has no representable quotient.
    function automatic logic is_ovf(input div_req_t r);
        return r.sign && (r.dividend == SIGNED_MIN) && (r.divisor == ALL_ONES);
    endfunction

endpackage

// File: rtl/div_req_fifo.sv
// Synchronous request FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module div_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/div_req_sequencer.sv
// Request FIFO + start-pulse sequencer in front of the iterative divider.
// Optional WAIT watchdog is compiled in with DIV_SEQ_TIMEOUT_EN.
//
// state     | meaning
// ST_IDLE   | pop next request into the operand register, decode special cases
// ST_START  | one-cycle div_start pulse
// ST_WAIT   | divider running, operands held, wait for div_ready (or watchdog)
// ST_BYPASS | load divide-by-zero / signed-overflow result without the divider
// ST_RESP   | rsp_valid held until rsp_ready
module div_req_sequencer
    import div_pkg::*;
#(
    parameter int DIV_WIDTH      = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_sign,
    input  logic [DIV_WIDTH-1:0] req_dividend,
    input  logic [DIV_WIDTH-1:0] req_divisor,
    output logic                 div_start,
    output logic                 div_sign,
    output logic [DIV_WIDTH-1:0] div_in1,
    output logic [DIV_WIDTH-1:0] div_in2,
    input  logic [DIV_WIDTH-1:0] div_q,
    input  logic [DIV_WIDTH-1:0] div_r,
    input  logic                 div_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DIV_WIDTH-1:0] rsp_q,
    output logic [DIV_WIDTH-1:0] rsp_r,
    output logic                 rsp_dbz,
    output logic                 rsp_ovf,
    output logic                 rsp_tmo
);

    if (DIV_WIDTH != DIV_W || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
        || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("div_req_sequencer: unsupported parameter set");
    end

    div_req_t             fifo_wdata, fifo_rdata;
    logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
    seq_state_t           state_q, state_d;
    div_req_t             op_q, op_d;
    logic                 div_start_q, div_start_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DIV_WIDTH-1:0] rsp_quo_q, rsp_quo_d;
    logic [DIV_WIDTH-1:0] rsp_rem_q, rsp_rem_d;
    logic                 rsp_dbz_q, rsp_dbz_d;
    logic                 rsp_ovf_q, rsp_ovf_d;
`ifdef DIV_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
    logic                 rsp_tmo_q, rsp_tmo_d;
`endif

    assign req_ready  = rst_n && !fifo_full;
    assign fifo_push  = req_valid && req_ready;
    assign fifo_wdata = {req_sign, req_dividend, req_divisor};

    div_req_fifo #(
        .WIDTH ($bits(div_req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        div_start_d = div_start_q;
        rsp_valid_d = rsp_valid_q;
        rsp_quo_d   = rsp_quo_q;
        rsp_rem_d   = rsp_rem_q;
        rsp_dbz_d   = rsp_dbz_q;
        rsp_ovf_d   = rsp_ovf_q;
        fifo_pop    = 1'b0;
`ifdef DIV_SEQ_TIMEOUT_EN
        wd_cnt_d    = wd_cnt_q;
        rsp_tmo_d   = rsp_tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op_d     = fifo_rdata;
                    if (is_dbz(fifo_rdata) || is_ovf(fifo_rdata)) begin
                        state_d = ST_BYPASS;
                    end else begin
                        state_d     = ST_START;
                        div_start_d = 1'b1;
                    end
                end
            end
            ST_START: begin
                div_start_d = 1'b0;
                state_d     = ST_WAIT;
`ifdef DIV_SEQ_TIMEOUT_EN
                wd_cnt_d    = WD_W'(TIMEOUT_CYCLES - 1);
`endif
            end
            ST_WAIT: begin
                if (div_ready) begin
                    rsp_quo_d   = div_q;
                    rsp_rem_d   = div_r;
                    rsp_dbz_d   = 1'b0;
                    rsp_ovf_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
`ifdef DIV_SEQ_TIMEOUT_EN
                    rsp_tmo_d   = 1'b0;
                end else if (wd_cnt_q == '0) begin
                    rsp_quo_d   = '0;
                    rsp_rem_d   = '0;
                    rsp_dbz_d   = 1'b0;
                    rsp_ovf_d   = 1'b0;
                    rsp_tmo_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    wd_cnt_d    = wd_cnt_q - 1'b1;
`endif
                end
            end
            ST_BYPASS: begin
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
`ifdef DIV_SEQ_TIMEOUT_EN
                rsp_tmo_d   = 1'b0;
`endif
                if (is_dbz(op_q)) begin
                    rsp_quo_d = ALL_ONES;
                    rsp_rem_d = op_q.dividend;
                    rsp_dbz_d = 1'b1;
                    rsp_ovf_d = 1'b0;
                end else begin
                    rsp_quo_d = SIGNED_MIN;
                    rsp_rem_d = '0;
                    rsp_dbz_d = 1'b0;
                    rsp_ovf_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            div_start_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_quo_q   <= '0;
            rsp_rem_q   <= '0;
            rsp_dbz_q   <= 1'b0;
            rsp_ovf_q   <= 1'b0;
`ifdef DIV_SEQ_TIMEOUT_EN
            wd_cnt_q    <= '0;
            rsp_tmo_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            div_start_q <= div_start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_quo_q   <= rsp_quo_d;
            rsp_rem_q   <= rsp_rem_d;
            rsp_dbz_q   <= rsp_dbz_d;
            rsp_ovf_q   <= rsp_ovf_d;
`ifdef DIV_SEQ_TIMEOUT_EN
            wd_cnt_q    <= wd_cnt_d;
            rsp_tmo_q   <= rsp_tmo_d;
`endif
        end
    end

    // The divider reads these combinationally, so they come straight from the operand register.
    assign div_start = div_start_q;
    assign div_sign  = op_q.sign;
    assign div_in1   = op_q.dividend;
    assign div_in2   = op_q.divisor;
    assign rsp_valid = rsp_valid_q;
    assign rsp_q     = rsp_quo_q;
    assign rsp_r     = rsp_rem_q;
    assign rsp_dbz   = rsp_dbz_q;
    assign rsp_ovf   = rsp_ovf_q;
`ifdef DIV_SEQ_TIMEOUT_EN
    assign rsp_tmo   = rsp_tmo_q;
`else
    assign rsp_tmo   = 1'b0;
`endif

endmodule

// File: tb/tb_div_req_sequencer.sv
// Directed bench for div_req_sequencer with a behavioural divider model; timeout steps run only with DIV_SEQ_TIMEOUT_EN.
module tb_div_req_sequencer;

    localparam int TMO = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_sign;
    logic [31:0] req_dividend, req_divisor;
    logic        div_start, div_sign;
    logic [31:0] div_in1, div_in2, div_q, div_r;
    logic        div_ready;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_q, rsp_r;
    logic        rsp_dbz, rsp_ovf, rsp_tmo;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_req_sequencer #(
        .DIV_WIDTH      (32),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_sign     (req_sign),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .div_start    (div_start),
        .div_sign     (div_sign),
        .div_in1      (div_in1),
        .div_in2      (div_in2),
        .div_q        (div_q),
        .div_r        (div_r),
        .div_ready    (div_ready),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_q        (rsp_q),
        .rsp_r        (rsp_r),
        .rsp_dbz      (rsp_dbz),
        .rsp_ovf      (rsp_ovf),
        .rsp_tmo      (rsp_tmo)
    );

    // Behavioural divider: drops ready the cycle after start, returns after a data-dependent delay.
    logic        busy;
    logic        div_hang = 1'b0;
    logic [31:0] lat_cnt, m_q, m_r, cap_a, cap_b;
    logic        cap_s;
    int          stab_err  = 0;
    int          start_cnt = 0;
    int          dbl_err   = 0;
    logic        start_prev = 1'b0;

    function automatic logic [31:0] mdl_q(input logic s, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return '1;
        if (s) return $signed(a) / $signed(b);
        return a / b;
    endfunction

    function automatic logic [31:0] mdl_r(input logic s, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return a;
        if (s) return $signed(a) % $signed(b);
        return a % b;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            div_ready <= 1'b1;
            busy      <= 1'b0;
            lat_cnt   <= '0;
            div_q     <= '0;
            div_r     <= '0;
        end else if (div_start) begin
            div_ready <= 1'b0;
            busy      <= 1'b1;
            cap_a     <= div_in1;
            cap_b     <= div_in2;
            cap_s     <= div_sign;
            m_q       <= mdl_q(div_sign, div_in1, div_in2);
            m_r       <= mdl_r(div_sign, div_in1, div_in2);
            lat_cnt   <= (mdl_q(div_sign, div_in1, div_in2) % 9) + 2;
        end else if (busy) begin
            if (div_in1 !== cap_a || div_in2 !== cap_b || div_sign !== cap_s)
                stab_err <= stab_err + 1;
            if (!div_hang) begin
                if (lat_cnt == 0) begin
                    div_ready <= 1'b1;
                    busy      <= 1'b0;
                    div_q     <= m_q;
                    div_r     <= m_r;
                end else begin
                    lat_cnt <= lat_cnt - 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        start_prev <= div_start;
        if (div_start) start_cnt <= start_cnt + 1;
        if (div_start && start_prev) dbl_err <= dbl_err + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic s, input logic [31:0] a, input logic [31:0] b);
        int k = 0;
        req_valid    = 1'b1;
        req_sign     = s;
        req_dividend = a;
        req_divisor  = b;
        while (!req_ready && k < 100) begin
            step();
            k++;
        end
        check1("send_ready", req_ready, 1'b1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic [31:0] eq, input logic [31:0] er,
                           input logic edbz, input logic eovf);
        int k = 0;
        rsp_ready = 1'b1;
        while (!rsp_valid && k < 200) begin
            step();
            k++;
        end
        check1({tag, "_valid"}, rsp_valid, 1'b1);
        check32({tag, "_q"}, rsp_q, eq);
        check32({tag, "_r"}, rsp_r, er);
        check1({tag, "_dbz"}, rsp_dbz, edbz);
        check1({tag, "_ovf"}, rsp_ovf, eovf);
        check1({tag, "_tmo"}, rsp_tmo, 1'b0);
        step();
        rsp_ready = 1'b0;
    endtask

    logic [31:0] bp_a [6], bp_b [6], bp_q [6], bp_r [6];
    logic        bp_s [6], bp_dbz [6];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1, "global timeout");
    end

    initial begin
        int base;
        int acc;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_sign     = 1'b0;
        req_dividend = '0;
        req_divisor  = '0;
        rsp_ready    = 1'b0;

        bp_s[0] = 0; bp_a[0] = 32'd1000;       bp_b[0] = 32'd10;         bp_q[0] = 32'd100;        bp_r[0] = 32'd0;          bp_dbz[0] = 0;
        bp_s[1] = 0; bp_a[1] = 32'd17;         bp_b[1] = 32'd5;          bp_q[1] = 32'd3;          bp_r[1] = 32'd2;          bp_dbz[1] = 0;
        bp_s[2] = 1; bp_a[2] = 32'hFFFF_FFF9;  bp_b[2] = 32'd2;          bp_q[2] = 32'hFFFF_FFFD;  bp_r[2] = 32'hFFFF_FFFF;  bp_dbz[2] = 0;
        bp_s[3] = 0; bp_a[3] = 32'd9;          bp_b[3] = 32'd0;          bp_q[3] = 32'hFFFF_FFFF;  bp_r[3] = 32'd9;          bp_dbz[3] = 1;
        bp_s[4] = 1; bp_a[4] = 32'd7;          bp_b[4] = 32'hFFFF_FFFE;  bp_q[4] = 32'hFFFF_FFFD;  bp_r[4] = 32'd1;          bp_dbz[4] = 0;
        bp_s[5] = 0; bp_a[5] = 32'hFFFF_FFFF;  bp_b[5] = 32'd16;         bp_q[5] = 32'h0FFF_FFFF;  bp_r[5] = 32'd15;         bp_dbz[5] = 0;

        // reset values
        repeat (3) step();
        check1("rst_rsp_valid", rsp_valid, 1'b0);
        check32("rst_rsp_q", rsp_q, 32'd0);
        check32("rst_rsp_r", rsp_r, 32'd0);
        check1("rst_dbz", rsp_dbz, 1'b0);
        check1("rst_ovf", rsp_ovf, 1'b0);
        check1("rst_tmo", rsp_tmo, 1'b0);
        check1("rst_div_start", div_start, 1'b0);
        check32("rst_div_in1", div_in1, 32'd0);
        check32("rst_div_in2", div_in2, 32'd0);
        check1("rst_req_ready", req_ready, 1'b0);
        rst_n = 1'b1;
        step();
        check1("post_rst_req_ready", req_ready, 1'b1);

        // unsigned 100/7
        base = start_cnt;
        send(1'b0, 32'd100, 32'd7);
        get_rsp("u100_7", 32'd14, 32'd2, 1'b0, 1'b0);
        checki("u100_7_starts", start_cnt - base, 1);

        // signed -100/7
        send(1'b1, 32'hFFFF_FF9C, 32'd7);
        get_rsp("s-100_7", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);

        // divide by zero: bypass, rsp_valid two cycles after the pop
        base = start_cnt;
        send(1'b0, 32'd5, 32'd0);
        step();
        check1("dbz_valid_pop_p1", rsp_valid, 1'b0);
        step();
        check1("dbz_valid_pop_p2", rsp_valid, 1'b1);
        get_rsp("u5_0", 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
        checki("dbz_no_start", start_cnt - base, 0);

        // signed overflow bypass
        base = start_cnt;
        send(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        get_rsp("s_ovf", 32'h8000_0000, 32'd0, 1'b0, 1'b1);
        checki("ovf_no_start", start_cnt - base, 0);

        // same operands unsigned are an ordinary divide
        send(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        get_rsp("u_min_ones", 32'd0, 32'h8000_0000, 1'b0, 1'b0);

        // back-pressure: 6 offered, 5 accepted (4 in FIFO, 1 held in RESP)
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            req_valid    = 1'b1;
            req_sign     = bp_s[i];
            req_dividend = bp_a[i];
            req_divisor  = bp_b[i];
            if (req_ready) acc++;
            step();
        end
        req_valid = 1'b0;
        repeat (30) step();
        checki("bp_accepted", acc, 5);
        check1("bp_req_ready_full", req_ready, 1'b0);
        check1("bp_rsp_held", rsp_valid, 1'b1);
        check32("bp_held_q", rsp_q, bp_q[0]);
        for (int i = 0; i < 5; i++) begin
            get_rsp($sformatf("bp%0d", i), bp_q[i], bp_r[i], bp_dbz[i], 1'b0);
        end
        check1("bp_drained_ready", req_ready, 1'b1);
        send(bp_s[5], bp_a[5], bp_b[5]);
        get_rsp("bp5", bp_q[5], bp_r[5], 1'b0, 1'b0);

        // reset during WAIT with one request still queued
        base = start_cnt;
        send(1'b0, 32'd200, 32'd3);
        send(1'b0, 32'd10, 32'd3);
        step();
        check1("wait_div_start_low", div_start, 1'b0);
        check1("wait_rsp_valid_low", rsp_valid, 1'b0);
        checki("wait_one_start", start_cnt - base, 1);
        rst_n = 1'b0;
        step();
        check1("abort_rsp_valid", rsp_valid, 1'b0);
        check1("abort_div_start", div_start, 1'b0);
        check32("abort_div_in1", div_in1, 32'd0);
        check32("abort_div_in2", div_in2, 32'd0);
        check32("abort_rsp_q", rsp_q, 32'd0);
        check32("abort_rsp_r", rsp_r, 32'd0);
        check1("abort_req_ready", req_ready, 1'b0);
        rst_n = 1'b1;
        repeat (6) step();
        checki("abort_fifo_empty", start_cnt - base, 1);
        check1("abort_no_rsp", rsp_valid, 1'b0);
        check1("abort_req_ready_back", req_ready, 1'b1);
        send(1'b0, 32'd10, 32'd3);
        get_rsp("after_abort", 32'd3, 32'd1, 1'b0, 1'b0);

`ifdef DIV_SEQ_TIMEOUT_EN
        begin
            int k = 0;
            div_hang = 1'b1;
            send(1'b0, 32'd50, 32'd5);
            step();
            step();
            while (!rsp_valid && k < TMO + 20) begin
                step();
                k++;
            end
            checki("tmo_cycles", k, TMO);
            check1("tmo_flag", rsp_tmo, 1'b1);
            check32("tmo_q", rsp_q, 32'd0);
            check32("tmo_r", rsp_r, 32'd0);
            rst_n = 1'b0;
            step();
            rst_n    = 1'b1;
            div_hang = 1'b0;
            step();
        end
`endif

        checki("double_start", dbl_err, 0);
        checki("operand_stable", stab_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
